// File: rtl/boss_contact_damage_pkg.sv
// boss_contact_damage_pkg: shared contact FSM state, frame timing and character size constants
package boss_contact_damage_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, INVULN, DEAD} contact_state_t;
    localparam int FRAME_TICKS = 1083333;
    localparam int FRAME_CNT_W = 21;
    localparam int CHAR_HALF_W = 16;
    localparam int CHAR_HALF_H = 24;
endpackage

// File: rtl/boss_contact_damage_frame_ticker.sv
// boss_contact_damage_frame_ticker: free-running frame counter with a one-cycle tick on wrap
module boss_contact_damage_frame_ticker import boss_contact_damage_pkg::*; #(
    parameter int FRAME_TICKS = boss_contact_damage_pkg::FRAME_TICKS
) (
    input  logic clk,
    input  logic rst,
    output logic frame_tick
);
    logic [FRAME_CNT_W-1:0] cnt;
    assign frame_tick = cnt == FRAME_CNT_W'(FRAME_TICKS - 1);
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else      cnt <= frame_tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/boss_contact_damage.sv
// boss_contact_damage: once-per-frame boss body contact, character HP, invulnerability and knockback
module boss_contact_damage import boss_contact_damage_pkg::*; #(
    parameter int FRAME_TICKS   = boss_contact_damage_pkg::FRAME_TICKS,
    parameter int CHAR_HALF_W   = boss_contact_damage_pkg::CHAR_HALF_W,
    parameter int CHAR_HALF_H   = boss_contact_damage_pkg::CHAR_HALF_H,
    parameter int CHAR_HP_MAX   = 10,
    parameter int DAMAGE        = 2,
    parameter int INVULN_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_active,
    input  logic [11:0] char_x,
    input  logic [11:0] char_y,
    input  logic [11:0] boss_x,
    input  logic [11:0] boss_y,
    input  logic [11:0] boss_lng,
    input  logic [11:0] boss_hgt,
    input  logic [6:0]  boss_hp,
    output logic [3:0]  char_hp,
    output logic        char_hit,
    output logic        char_invuln,
    output logic        knock_left,
    output logic        char_dead
);
    contact_state_t state, state_n;
    logic [3:0] hp, hp_n, hp_hit;
    logic [7:0] frames, frames_n;
    logic hit_n, knock_n, frame_tick, overlap;
    logic signed [12:0] dx_s, dy_s;
    logic [12:0] dx, dy, reach_x, reach_y;

    boss_contact_damage_frame_ticker #(.FRAME_TICKS(FRAME_TICKS)) u_ticker (
        .clk(clk),
        .rst(rst),
        .frame_tick(frame_tick)
    );

    // Touching edges are not contact, hence strict less-than
    assign dx_s    = $signed({1'b0, boss_x}) - $signed({1'b0, char_x});
    assign dy_s    = $signed({1'b0, boss_y}) - $signed({1'b0, char_y});
    assign dx      = dx_s[12] ? -dx_s : dx_s;
    assign dy      = dy_s[12] ? -dy_s : dy_s;
    assign reach_x = {2'b0, boss_lng[11:1]} + 13'(CHAR_HALF_W);
    assign reach_y = {2'b0, boss_hgt[11:1]} + 13'(CHAR_HALF_H);
    assign overlap = (dx < reach_x) && (dy < reach_y);
    assign hp_hit  = hp > 4'(DAMAGE) ? hp - 4'(DAMAGE) : '0;

    assign char_hp     = hp;
    assign char_invuln = state == INVULN;
    assign char_dead   = state == DEAD;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state      <= IDLE;
            hp         <= 4'(CHAR_HP_MAX);
            frames     <= '0;
            char_hit   <= 1'b0;
            knock_left <= 1'b0;
        end else begin
            state      <= state_n;
            hp         <= hp_n;
            frames     <= frames_n;
            char_hit   <= hit_n;
            knock_left <= knock_n;
        end

    always_comb begin
        state_n  = state;
        hp_n     = hp;
        frames_n = frames;
        hit_n    = 1'b0;
        knock_n  = knock_left;
        if (!game_active) begin
            state_n  = IDLE;
            hp_n     = 4'(CHAR_HP_MAX);
            frames_n = '0;
            knock_n  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = ARMED;
                    hp_n    = 4'(CHAR_HP_MAX);
                end
                ARMED:
                    if (frame_tick && overlap && boss_hp != '0) begin
                        hp_n     = hp_hit;
                        hit_n    = 1'b1;
                        knock_n  = char_x < boss_x;
                        frames_n = 8'(INVULN_FRAMES);
                        state_n  = hp_hit == '0 ? DEAD : INVULN;
                    end
                INVULN:
                    if (frame_tick) begin
                        frames_n = frames - 1'b1;
                        state_n  = frames == 8'd1 ? ARMED : INVULN;
                    end
                DEAD:    hp_n = '0;
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_boss_contact_damage.sv
// tb_boss_contact_damage: directed checks of contact damage, invulnerability, saturation and reset
module tb_boss_contact_damage;
    logic clk, rst, game_active;
    logic [11:0] char_x, char_y, boss_x, boss_y, boss_lng, boss_hgt;
    logic [6:0] boss_hp;
    logic [3:0] hp, hp3;
    logic hit, inv, knock, dead, hit3, inv3, knock3, dead3;
    int vectors = 0;
    int miscompares = 0;
    int ec;
    int hits;

    boss_contact_damage #(.FRAME_TICKS(10), .INVULN_FRAMES(3)) dut (
        .clk(clk), .rst(rst), .game_active(game_active),
        .char_x(char_x), .char_y(char_y), .boss_x(boss_x), .boss_y(boss_y),
        .boss_lng(boss_lng), .boss_hgt(boss_hgt), .boss_hp(boss_hp),
        .char_hp(hp), .char_hit(hit), .char_invuln(inv), .knock_left(knock), .char_dead(dead)
    );

    boss_contact_damage #(.FRAME_TICKS(10), .INVULN_FRAMES(3), .CHAR_HP_MAX(3)) dut3 (
        .clk(clk), .rst(rst), .game_active(game_active),
        .char_x(char_x), .char_y(char_y), .boss_x(boss_x), .boss_y(boss_y),
        .boss_lng(boss_lng), .boss_hgt(boss_hgt), .boss_hp(boss_hp),
        .char_hp(hp3), .char_hit(hit3), .char_invuln(inv3), .knock_left(knock3), .char_dead(dead3)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Edges since reset release; a frame tick lands on every edge that is a multiple of 10
    always @(posedge clk or negedge rst)
        if (!rst) ec <= 0;
        else      ec <= ec + 1;

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, got %0d edges required under 5000", ec);
        $fatal(1);
    end

    task automatic wait_edge(input int k);
        while (ec < k) @(negedge clk);
    endtask

    task automatic watch(input int k, output int n);
        n = 0;
        while (ec < k) begin
            @(negedge clk);
            if (hit) n++;
        end
    endtask

    task automatic test_reset;
        rst = 0; game_active = 0; boss_hp = 50;
        char_x = 100; char_y = 100;
        boss_x = 500; boss_y = 400; boss_lng = 212; boss_hgt = 191;
        @(negedge clk);
        vectors++;
        if ({hp, hit, inv, knock, dead} !== {4'd10, 4'b0000}) begin
            miscompares++;
            $display("FAIL reset_outputs: got hp=%0d hit=%b inv=%b knock=%b dead=%b required hp=10 rest 0", hp, hit, inv, knock, dead);
        end
        vectors++;
        if (hp3 !== 4'd3) begin
            miscompares++;
            $display("FAIL reset_hp3: got %0d required 3", hp3);
        end
        rst = 1;
        game_active = 1;
    endtask

    task automatic test_no_overlap;
        watch(200, hits);
        vectors++;
        if (hits !== 0) begin
            miscompares++;
            $display("FAIL no_overlap_hits: got %0d hits required 0", hits);
        end
        vectors++;
        if (hp !== 4'd10) begin
            miscompares++;
            $display("FAIL no_overlap_hp: got %0d required 10", hp);
        end
    endtask

    task automatic test_hit;
        char_x = 450; char_y = 400;
        wait_edge(209);
        vectors++;
        if (hp !== 4'd10 || hit !== 1'b0) begin
            miscompares++;
            $display("FAIL pre_tick: got hp=%0d hit=%b required hp=10 hit=0", hp, hit);
        end
        wait_edge(210);
        vectors++;
        if ({hp, hit, knock, inv} !== {4'd8, 3'b111}) begin
            miscompares++;
            $display("FAIL first_hit: got hp=%0d hit=%b knock=%b inv=%b required hp=8 hit=1 knock=1 inv=1", hp, hit, knock, inv);
        end
        wait_edge(211);
        vectors++;
        if (hit !== 1'b0) begin
            miscompares++;
            $display("FAIL hit_pulse_width: got hit=%b required 0", hit);
        end
        wait_edge(239);
        vectors++;
        if (inv !== 1'b1) begin
            miscompares++;
            $display("FAIL invuln_end_of_window: got %b required 1", inv);
        end
        wait_edge(240);
        vectors++;
        if (inv !== 1'b0 || hp !== 4'd8) begin
            miscompares++;
            $display("FAIL invuln_released: got inv=%b hp=%0d required inv=0 hp=8", inv, hp);
        end
        watch(250, hits);
        vectors++;
        if (hp !== 4'd6 || hit !== 1'b1 || hits !== 1) begin
            miscompares++;
            $display("FAIL second_hit: got hp=%0d hit=%b hits=%0d required hp=6 hit=1 hits=1", hp, hit, hits);
        end
    endtask

    task automatic test_edge;
        game_active = 0;
        wait_edge(251);
        vectors++;
        if ({hp, inv, knock} !== {4'd10, 2'b00}) begin
            miscompares++;
            $display("FAIL game_stop_restore: got hp=%0d inv=%b knock=%b required hp=10 inv=0 knock=0", hp, inv, knock);
        end
        game_active = 1;
        char_x = 378; char_y = 400;
        watch(270, hits);
        vectors++;
        if (hits !== 0 || hp !== 4'd10) begin
            miscompares++;
            $display("FAIL touching_edge: got hits=%0d hp=%0d required hits=0 hp=10", hits, hp);
        end
        char_x = 379;
        wait_edge(280);
        vectors++;
        if (hp !== 4'd8 || hit !== 1'b1) begin
            miscompares++;
            $display("FAIL one_pixel_in: got hp=%0d hit=%b required hp=8 hit=1", hp, hit);
        end
    endtask

    task automatic test_saturate;
        game_active = 0;
        wait_edge(281);
        game_active = 1;
        char_x = 600; char_y = 400;
        wait_edge(290);
        vectors++;
        if ({hp3, hit3, knock3, dead3} !== {4'd1, 3'b100}) begin
            miscompares++;
            $display("FAIL sat_first_hit: got hp=%0d hit=%b knock=%b dead=%b required hp=1 hit=1 knock=0 dead=0", hp3, hit3, knock3, dead3);
        end
        wait_edge(330);
        vectors++;
        if ({hp3, hit3, dead3, inv3} !== {4'd0, 3'b110}) begin
            miscompares++;
            $display("FAIL sat_to_zero: got hp=%0d hit=%b dead=%b inv=%b required hp=0 hit=1 dead=1 inv=0", hp3, hit3, dead3, inv3);
        end
        wait_edge(340);
        vectors++;
        if (hp3 !== 4'd0 || dead3 !== 1'b1) begin
            miscompares++;
            $display("FAIL dead_holds: got hp=%0d dead=%b required hp=0 dead=1", hp3, dead3);
        end
        game_active = 0;
        wait_edge(341);
        vectors++;
        if ({hp3, dead3, hp} !== {4'd3, 1'b0, 4'd10}) begin
            miscompares++;
            $display("FAIL dead_exit: got hp3=%0d dead=%b hp=%0d required hp3=3 dead=0 hp=10", hp3, dead3, hp);
        end
    endtask

    task automatic test_boss_dead;
        game_active = 1;
        boss_hp = 0;
        char_x = 450; char_y = 400;
        watch(445, hits);
        vectors++;
        if (hits !== 0 || hp !== 4'd10) begin
            miscompares++;
            $display("FAIL boss_dead_no_hit: got hits=%0d hp=%0d required hits=0 hp=10", hits, hp);
        end
        boss_hp = 50;
        wait_edge(449);
        game_active = 0;
        wait_edge(450);
        vectors++;
        if ({hp, hit, inv} !== {4'd10, 2'b00}) begin
            miscompares++;
            $display("FAIL stop_beats_hit: got hp=%0d hit=%b inv=%b required hp=10 hit=0 inv=0", hp, hit, inv);
        end
    endtask

    task automatic test_async_reset;
        game_active = 1;
        wait_edge(460);
        vectors++;
        if (hp !== 4'd8 || inv !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_hit: got hp=%0d inv=%b required hp=8 inv=1", hp, inv);
        end
        wait_edge(465);
        #2 rst = 0;
        #1;
        vectors++;
        if ({hp, hit, inv, knock, dead} !== {4'd10, 4'b0000}) begin
            miscompares++;
            $display("FAIL async_reset: got hp=%0d hit=%b inv=%b knock=%b dead=%b required hp=10 rest 0", hp, hit, inv, knock, dead);
        end
        @(negedge clk);
        rst = 1;
        wait_edge(9);
        vectors++;
        if (hp !== 4'd10) begin
            miscompares++;
            $display("FAIL ticker_restart_early: got hp=%0d required 10", hp);
        end
        wait_edge(10);
        vectors++;
        if (hp !== 4'd8 || hit !== 1'b1) begin
            miscompares++;
            $display("FAIL ticker_restart_hit: got hp=%0d hit=%b required hp=8 hit=1", hp, hit);
        end
    endtask

    initial begin
        test_reset;
        test_no_overlap;
        test_hit;
        test_edge;
        test_saturate;
        test_boss_dead;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
